// File: rtl/pcss_pkg.sv
// Shared spike-path types and constants: spike id layout {z,y,x}, spike codes,
// and the output-stage state encoding.
package pcss_pkg;

  localparam int unsigned SW_DEF = 24;
  localparam int unsigned CW     = SW_DEF / 3;

  typedef enum logic [1:0] {
    LIF          = 2'b00,
    CODE_COUNT   = 2'b01,
    CODE_POISSON = 2'b10
  } spk_code_e;

  typedef struct packed {
    logic [CW-1:0] z;
    logic [CW-1:0] y;
    logic [CW-1:0] x;
  } spk_id_t;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_VALID = 1'b1
  } out_state_e;

  function automatic logic [SW_DEF-1:0] spk_pack(input logic [CW-1:0] z,
                                                 input logic [CW-1:0] y,
                                                 input logic [CW-1:0] x);
    return {z, y, x};
  endfunction

  function automatic spk_id_t spk_unpack(input logic [SW_DEF-1:0] id);
    return spk_id_t'(id);
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with occupancy count; push/pop are ignored when full/empty.
// Pointers are AW bits and wrap naturally, so DEPTH must equal 2**AW.
module sync_fifo #(
  parameter int unsigned W     = 24,
  parameter int unsigned DEPTH = 16,
  parameter int unsigned AW    = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clear,
  input  logic          push,
  input  logic [W-1:0]  push_data,
  input  logic          pop,
  output logic [W-1:0]  pop_data,
  output logic [AW:0]   count
);

  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  always_comb begin
    do_push = push && (count != FULL_CNT);
    do_pop  = pop && (count != '0);
  end

  // Storage carries no reset; validity is tracked by the count alone.
  always_ff @(posedge clk) begin
    if (do_push && !clear) begin
      mem[wr_ptr] <= push_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end

  assign pop_data = mem[rd_ptr];

endmodule

// File: rtl/spk_out_buf.sv
// Spike-output buffer: queues fired-neuron ids from the work pipeline, throttles
// it with an almost-full flag, and drains to the router through one output register.
module spk_out_buf
  import pcss_pkg::*;
#(
  parameter int unsigned SW        = SW_DEF,
  parameter int unsigned DEPTH     = 16,
  parameter int unsigned AW        = 4,
  parameter int unsigned AF_MARGIN = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [SW-1:0] config_spk_out_neuid,
  input  logic          soma_spk_vld,
  input  logic          config_clear,
  output logic          spk_out_config_full,
  output logic          spk_out_vld,
  output logic [SW-1:0] spk_out_data,
  input  logic          spk_out_rdy,
  output logic          spk_out_empty,
  output logic          spk_out_overflow
);

  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);
  localparam logic [AW:0] AF_CNT   = (AW+1)'(DEPTH - AF_MARGIN);

  out_state_e    state;
  logic [AW:0]   count;
  logic [SW-1:0] pop_data;
  logic          push_c;
  logic          pop_c;
  logic [AW:0]   count_next_c;

  // Push/pop decisions use the current count, so a full FIFO drops even when popping.
  always_comb begin
    push_c       = soma_spk_vld && !config_clear && (count != FULL_CNT);
    pop_c        = !config_clear && (count != '0) &&
                   ((state == ST_EMPTY) || spk_out_rdy);
    count_next_c = count + (AW+1)'(push_c) - (AW+1)'(pop_c);
  end

  sync_fifo #(
    .W     (SW),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear     (config_clear),
    .push      (push_c),
    .push_data (config_spk_out_neuid),
    .pop       (pop_c),
    .pop_data  (pop_data),
    .count     (count)
  );

  // Output stage, almost-full and sticky overflow.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state               <= ST_EMPTY;
      spk_out_data        <= '0;
      spk_out_config_full <= 1'b0;
      spk_out_overflow    <= 1'b0;
    end else if (config_clear) begin
      state               <= ST_EMPTY;
      spk_out_config_full <= 1'b0;
      spk_out_overflow    <= 1'b0;
    end else begin
      if (pop_c) begin
        spk_out_data <= pop_data;
        state        <= ST_VALID;
      end else if (spk_out_rdy) begin
        state <= ST_EMPTY;
      end
      spk_out_config_full <= (count_next_c >= AF_CNT);
      if (soma_spk_vld && !push_c) begin
        spk_out_overflow <= 1'b1;
      end
    end
  end

  assign spk_out_vld   = (state == ST_VALID);
  assign spk_out_empty = (count == '0) && !spk_out_vld;

endmodule
